// File: rtl/pipelined_adder.sv
// N-bit add/subtract with the carry chain cut into STAGES registered chunks.
// Operands travel with the partial sum so each stage only resolves its own W-bit slice.
module pipelined_adder #(
    parameter int N      = 8,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int W = N / STAGES;

    if (N < 1 || STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_params
        $error("pipelined_adder: N must be a positive multiple of STAGES with STAGES <= N");
    end

    logic              en;
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [N-1:0]      a_q   [STAGES];
    logic [N-1:0]      a_d   [STAGES];
    logic [N-1:0]      bx_q  [STAGES];
    logic [N-1:0]      bx_d  [STAGES];
    logic [N-1:0]      res_q [STAGES];
    logic [N-1:0]      res_d [STAGES];
    logic              ovf_q, ovf_d;

    // Working copies of whatever feeds the stage currently being evaluated.
    logic [N-1:0]      a_in, bx_in, res_in;
    logic              c_in, v_in;
    logic [W:0]        part;

    always_comb begin
        en     = !vld_q[STAGES-1] || out_ready;
        vld_d  = vld_q;
        c_d    = c_q;
        a_d    = a_q;
        bx_d   = bx_q;
        res_d  = res_q;
        ovf_d  = ovf_q;
        a_in   = a;
        bx_in  = b ^ {N{sub}};
        c_in   = ci ^ sub;
        res_in = '0;
        v_in   = in_valid;
        part   = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (k > 0) begin
                a_in   = a_q[(k > 0) ? k - 1 : 0];
                bx_in  = bx_q[(k > 0) ? k - 1 : 0];
                res_in = res_q[(k > 0) ? k - 1 : 0];
                c_in   = c_q[(k > 0) ? k - 1 : 0];
                v_in   = vld_q[(k > 0) ? k - 1 : 0];
            end
            part = {1'b0, a_in[k*W +: W]} + {1'b0, bx_in[k*W +: W]} + {{W{1'b0}}, c_in};
            res_in[k*W +: W] = part[W-1:0];
            // A single global enable keeps every stage in lockstep, so stalls never reorder.
            if (en) begin
                vld_d[k] = v_in;
                c_d[k]   = part[W];
                a_d[k]   = a_in;
                bx_d[k]  = bx_in;
                res_d[k] = res_in;
            end
        end
        // After the loop the working copies hold the last stage's full operands and sum.
        if (en) begin
            ovf_d = (a_in[N-1] == bx_in[N-1]) && (res_in[N-1] != a_in[N-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                bx_q[k]  <= '0;
                res_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            c_q   <= c_d;
            ovf_q <= ovf_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                bx_q[k]  <= bx_d[k];
                res_q[k] <= res_d[k];
            end
        end
    end

    assign in_ready  = en;
    assign out_valid = vld_q[STAGES-1];
    assign sum       = res_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule
